// File: rtl/icache_tag_ram_ctrl_pkg.sv
// Shared types and constants for the L1.5 icache tag RAM controller.
package icache_tag_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 7;   // valid bit + tag
    localparam int unsigned ADDR_WIDTH = 6;   // depth = 2**ADDR_WIDTH

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Value written to every entry during an invalidation sweep (valid bit cleared).
    localparam logic [DATA_WIDTH-1:0] FLUSH_WDATA = '0;

endpackage

// File: rtl/icache_tag_ram_ctrl_if.sv
// Bundles the requester, flush and tag RAM signals of the tag RAM controller.
// slave = the controller itself, master = cache controller / tag RAM side.
interface icache_tag_ram_ctrl_if
    import icache_tag_ctrl_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH,
    parameter int unsigned AW = ADDR_WIDTH
) ();

    logic          flush_req_i;
    logic          flush_ack_o;
    logic          busy_o;
    logic          lookup_req_i;
    logic [AW-1:0] lookup_addr_i;
    logic          lookup_gnt_o;
    logic          lookup_rvalid_o;
    logic [DW-1:0] lookup_rdata_o;
    logic          refill_req_i;
    logic [AW-1:0] refill_addr_i;
    logic [DW-1:0] refill_wdata_i;
    logic          refill_gnt_o;
    logic          ram_req_o;
    logic          ram_write_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    modport slave (
        input  flush_req_i, lookup_req_i, lookup_addr_i,
               refill_req_i, refill_addr_i, refill_wdata_i, ram_rdata_i,
        output flush_ack_o, busy_o, lookup_gnt_o, lookup_rvalid_o, lookup_rdata_o,
               refill_gnt_o, ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output flush_req_i, lookup_req_i, lookup_addr_i,
               refill_req_i, refill_addr_i, refill_wdata_i, ram_rdata_i,
        input  flush_ack_o, busy_o, lookup_gnt_o, lookup_rvalid_o, lookup_rdata_o,
               refill_gnt_o, ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o
    );

endinterface

// File: rtl/icache_tag_ram_ctrl.sv
// Single-port tag RAM controller: arbitrates the tag SRAM port between refill
// writes and lookup reads (flush > refill > lookup) and runs invalidate-all sweeps.
// Optional feature macro: ICACHE_TAG_RESET_FLUSH_EN -- reset into a sweep that
// invalidates the array automatically and completes without pulsing flush_ack_o.
module icache_tag_ram_ctrl
    import icache_tag_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    icache_tag_ram_ctrl_if.slave  bus
);

`ifdef ICACHE_TAG_RESET_FLUSH_EN
    localparam state_t RESET_STATE = FLUSH;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_flush_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic                  r_rvalid;
    logic                  w_rst_sweep;

    logic                  w_refill_gnt;
    logic                  w_lookup_gnt;
    logic                  w_ram_req;
    logic                  w_ram_write;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic                  w_busy;
    logic                  w_ack;

`ifdef ICACHE_TAG_RESET_FLUSH_EN
    logic r_rst_sweep;

    // Marks the sweep launched by reset so its completion is not acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_sweep <= 1'b1;
        end else if (r_state == DONE) begin
            r_rst_sweep <= 1'b0;
        end
    end

    assign w_rst_sweep = r_rst_sweep;
`else
    assign w_rst_sweep = 1'b0;
`endif

    // State, sweep index and lookup read-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_STATE;
            r_flush_cnt <= '0;
            r_rvalid    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_flush_cnt <= w_cnt_next;
            r_rvalid    <= w_lookup_gnt;
        end
    end

    // Next-state, arbitration and RAM port decode.
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_flush_cnt;
        w_refill_gnt = 1'b0;
        w_lookup_gnt = 1'b0;
        w_ram_req    = 1'b0;
        w_ram_write  = 1'b0;
        w_ram_addr   = '0;
        w_ram_wdata  = '0;
        w_busy       = 1'b0;
        w_ack        = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.flush_req_i) begin
                    w_next = FLUSH;
                end else if (bus.refill_req_i) begin
                    w_refill_gnt = 1'b1;
                    w_ram_req    = 1'b1;
                    w_ram_write  = 1'b1;
                    w_ram_addr   = bus.refill_addr_i;
                    w_ram_wdata  = bus.refill_wdata_i;
                end else if (bus.lookup_req_i) begin
                    w_lookup_gnt = 1'b1;
                    w_ram_req    = 1'b1;
                    w_ram_addr   = bus.lookup_addr_i;
                end
            end
            FLUSH: begin
                w_busy      = 1'b1;
                w_ram_req   = 1'b1;
                w_ram_write = 1'b1;
                w_ram_addr  = r_flush_cnt;
                w_ram_wdata = FLUSH_WDATA;
                w_cnt_next  = ADDR_WIDTH'(r_flush_cnt + 1'b1);
                if (r_flush_cnt == '1) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_ack  = ~w_rst_sweep;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Grants and RAM requests are held off while reset is asserted.
    assign bus.refill_gnt_o    = w_refill_gnt & ~rst;
    assign bus.lookup_gnt_o    = w_lookup_gnt & ~rst;
    assign bus.ram_req_o       = w_ram_req & ~rst;
    assign bus.ram_write_o     = w_ram_write;
    assign bus.ram_addr_o      = w_ram_addr;
    assign bus.ram_wdata_o     = w_ram_wdata;
    assign bus.busy_o          = w_busy;
    assign bus.flush_ack_o     = w_ack;
    assign bus.lookup_rvalid_o = r_rvalid;
    assign bus.lookup_rdata_o  = bus.ram_rdata_i;

endmodule
